// File: rtl/xst_tx_sched.sv
// xst_tx_sched: round-robin scheduler framing client bytes into the xst serial transmitter
// Ports: clk_i/reset_i (sync, active-high); req_i/dat_i per-requester level request and byte;
//   ack_o capture pulse, grant_o one-hot owner, busy_o non-idle; xst_dat_o/xst_bits_o/xst_we_o
//   drive xst dat_i/bits_i/txreg_we_i; xst_idle_i from xst idle_o.
// Optional XST_TX_SCHED_PARITY_EN adds par_odd_i (1 = odd, 0 = even) and a parity bit after the data.
module xst_tx_sched #(
  parameter int REQUESTERS = 4,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [REQUESTERS-1:0]   req_i,
  input  logic [REQUESTERS*8-1:0] dat_i,
  output logic [REQUESTERS-1:0]   ack_o,
  output logic [REQUESTERS-1:0]   grant_o,
  output logic                    busy_o,
  output logic [63:0]             xst_dat_o,
  output logic [5:0]              xst_bits_o,
  output logic                    xst_we_o,
  input  logic                    xst_idle_i
`ifdef XST_TX_SCHED_PARITY_EN
  ,
  input  logic                    par_odd_i
`endif
);
  localparam int PW = $clog2(REQUESTERS);
`ifdef XST_TX_SCHED_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam logic [5:0] FRAME_BITS = 6'(1 + DATA_BITS + P + STOP_BITS);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_IDLE} state_t;
  state_t                 state;
  logic [PW-1:0]          ptr, win, win_r, idx;
  logic [REQUESTERS-1:0]  win_oh;
  logic [7:0]             byte_sel;
  logic [DATA_BITS-1:0]   data;
  logic [63:0]            frame;
  int                     s;
  // Search downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    win = ptr;
    s = 0;
    idx = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      s = s >= REQUESTERS ? s - REQUESTERS : s;
      idx = PW'(s);
      win = req_i[idx] ? idx : win;
    end
    byte_sel = dat_i[7:0];
    win_oh = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      byte_sel = win == PW'(k) ? dat_i[k*8 +: 8] : byte_sel;
      win_oh[k] = win == PW'(k);
    end
    data = byte_sel[DATA_BITS-1:0];
    // Stop bits and everything above them are ones, so only the count tracks STOP_BITS.
    frame = {{(63 - DATA_BITS){1'b1}}, data, 1'b0};
`ifdef XST_TX_SCHED_PARITY_EN
    frame[DATA_BITS+1] = par_odd_i ? ~^data : ^data;
`endif
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      ack_o      <= '0;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      xst_we_o   <= 1'b0;
      xst_dat_o  <= '1;
      xst_bits_o <= '0;
      ptr        <= '0;
      win_r      <= '0;
    end else begin
      case (state)
        IDLE: if (|req_i && xst_idle_i) begin
          state      <= LOAD;
          win_r      <= win;
          ack_o      <= win_oh;
          grant_o    <= win_oh;
          busy_o     <= 1'b1;
          xst_we_o   <= 1'b1;
          xst_dat_o  <= frame;
          xst_bits_o <= FRAME_BITS;
        end
        LOAD: begin
          state    <= WAIT_BUSY;
          xst_we_o <= 1'b0;
          ack_o    <= '0;
          ptr      <= win_r == PW'(REQUESTERS - 1) ? '0 : win_r + 1'b1;
        end
        WAIT_BUSY: state <= xst_idle_i ? WAIT_BUSY : WAIT_IDLE;
        WAIT_IDLE: if (xst_idle_i) begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xst_tx_sched.sv
// tb_xst_tx_sched: directed and randomized checks of xst_tx_sched against a behavioural model
module tb_xst_tx_sched;
  localparam int R  = 4;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef XST_TX_SCHED_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic          clk = 0, reset = 1;
  logic [R-1:0]  req = '0;
  logic [R*8-1:0] dat = '0;
  logic [R-1:0]  ack_o, grant_o;
  logic          busy_o, xst_we_o, xst_idle_i;
  logic [63:0]   xst_dat_o;
  logic [5:0]    xst_bits_o;
  logic          par_odd = 0;
  logic          stall = 0;
  logic          idle_r;
  int            cnt;
  int            vec = 0, err = 0;
  int            ptr = 0;
  int            w;
  always #5 clk = ~clk;
  xst_tx_sched #(.REQUESTERS(R), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .dat_i(dat), .ack_o(ack_o), .grant_o(grant_o),
    .busy_o(busy_o), .xst_dat_o(xst_dat_o), .xst_bits_o(xst_bits_o), .xst_we_o(xst_we_o),
    .xst_idle_i(xst_idle_i)
`ifdef XST_TX_SCHED_PARITY_EN
    , .par_odd_i(par_odd)
`endif
  );
  // Stand-in for the xst transmitter: busy for 4 clocks per bit after each load.
  assign xst_idle_i = idle_r & ~stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_r <= 1'b1;
      cnt    <= 0;
    end else if (xst_we_o) begin
      idle_r <= 1'b0;
      cnt    <= int'(xst_bits_o) * 4;
    end else if (cnt > 1) cnt <= cnt - 1;
    else if (cnt == 1) begin
      cnt    <= 0;
      idle_r <= 1'b1;
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) if (r[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction
  function automatic logic [63:0] model_frame(input logic [7:0] b, input logic odd);
    logic [63:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    if (P == 1) f[DB+1] = ((ones % 2) == 1) ^ odd;
    return f;
  endfunction
  // Waits for a load, checks it against the model, drops the winner's request, waits for the frame end.
  task automatic frame_check(input string tag, output int win);
    int n;
    logic [R-1:0] oh;
    n = 0;
    win = -1;
    while (!xst_we_o && n < 100) begin step; n++; end
    if (!xst_we_o) begin
      chk({tag, "-load-timeout"}, 0, 1);
      return;
    end
    win = pick(req, ptr);
    oh = '0;
    if (win >= 0) oh[win] = 1'b1;
    chk({tag, "-ack"}, 64'(ack_o), 64'(oh));
    chk({tag, "-grant"}, 64'(grant_o), 64'(oh));
    chk({tag, "-busy"}, 64'(busy_o), 1);
    chk({tag, "-bits"}, 64'(xst_bits_o), 64'(1 + DB + P + SB));
    if (win >= 0) begin
      chk({tag, "-dat"}, xst_dat_o, model_frame(dat[win*8 +: 8], par_odd));
      req[win] = 1'b0;
      ptr = (win + 1) % R;
    end
    step;
    chk({tag, "-ack-pulse"}, 64'(ack_o), 0);
    n = 0;
    while (busy_o && n < 200) begin step; n++; end
    chk({tag, "-end-busy"}, 64'(busy_o), 0);
    chk({tag, "-end-grant"}, 64'(grant_o), 0);
  endtask
  initial begin
    step;
    step;
    chk("rst-ack", 64'(ack_o), 0);
    chk("rst-grant", 64'(grant_o), 0);
    chk("rst-busy", 64'(busy_o), 0);
    chk("rst-we", 64'(xst_we_o), 0);
    chk("rst-bits", 64'(xst_bits_o), 0);
    chk("rst-dat", xst_dat_o, '1);
    reset = 0;
    dat = 32'h44_33_22_11;
    req = 4'b1111;
    for (int k = 0; k < R; k++) begin
      frame_check("rr", w);
      chk("rr-order", 64'(w), 64'(k));
    end
    req = 4'b1001;
    frame_check("rr2a", w);
    chk("rr2a-win", 64'(w), 0);
    frame_check("rr2b", w);
    chk("rr2b-win", 64'(w), 3);
    dat[7:0] = 8'h11;
    par_odd = 1;
    req = 4'b0001;
    frame_check("byte11", w);
    chk("byte11-lit", xst_dat_o, 64'hFFFF_FFFF_FFFF_FE22);
    chk("byte11-len", 64'(xst_bits_o), 64'(10 + P));
`ifdef XST_TX_SCHED_PARITY_EN
    par_odd = 0;
    req = 4'b0001;
    frame_check("byte11e", w);
    chk("byte11e-lit", xst_dat_o, 64'hFFFF_FFFF_FFFF_FC22);
`endif
    stall = 1;
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step;
      chk("stall-we", 64'(xst_we_o), 0);
      chk("stall-busy", 64'(busy_o), 0);
    end
    stall = 0;
    step;
    chk("unstall-we", 64'(xst_we_o), 1);
    frame_check("unstall", w);
    chk("unstall-win", 64'(w), 2);
    for (int it = 0; it < 16; it++) begin
      logic [R-1:0] nr;
      nr = 4'($urandom_range(1, 15));
      for (int k = 0; k < R; k++)
        if (nr[k] && !req[k]) begin
          dat[k*8 +: 8] = 8'($urandom);
          req[k] = 1'b1;
        end
      par_odd = 1'($urandom);
      frame_check("rand", w);
    end
    req = '0;
    step;
    req = 4'b0010;
    frame_check("pre-rst", w);
    req = 4'b0010;
    for (int n = 0; n < 100 && !xst_we_o; n++) step;
    chk("mid-we", 64'(xst_we_o), 1);
    req = '0;
    for (int k = 0; k < 6; k++) step;
    chk("mid-busy", 64'(busy_o), 1);
    reset = 1;
    step;
    reset = 0;
    ptr = 0;
    chk("abort-busy", 64'(busy_o), 0);
    chk("abort-grant", 64'(grant_o), 0);
    chk("abort-we", 64'(xst_we_o), 0);
    req = 4'b1010;
    frame_check("post-rst", w);
    chk("post-rst-win", 64'(w), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
